ddr2_port_arbiter: RTL and testbench

DDR2_PORT_ARBITER -- requirements
Module: ddr2_port_arbiter

---
 rtl/ddr2_port_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 tb/tb_ddr2_port_arbiter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr2_port_arbiter.sv
// ddr2_port_arbiter
// Two-port command arbiter in front of a DDR2 controller app interface.
// Each port issues one command at a time. The command is latched into the
// app_* registers, held until the controller accepts it, and then acked.
// Read ports are recorded in a small tag FIFO so that returning read data
// can be steered back to the port that issued the read.
// Optional feature: define DDR2_ARB_ROUND_ROBIN_EN to break ties in favour
// of the port that was not granted last. Without it, port 0 wins every tie.

module ddr2_port_arbiter #(
  parameter int ADDR_W    = 27,
  parameter int DATA_W    = 128,
  parameter int TAG_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  // port 0
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_rvalid,
  // port 1
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_rvalid,
  // controller app interface
  input  logic              app_rdy,
  input  logic              app_wdf_rdy,
  input  logic [DATA_W-1:0] app_rd_data,
  input  logic              app_rd_data_valid,
  output logic              app_en,
  output logic [2:0]        app_cmd,
  output logic [ADDR_W-1:0] app_addr,
  output logic              app_wdf_wren,
  output logic              app_wdf_end,
  output logic [DATA_W-1:0] app_wdf_data,
  output logic              rd_orphan_err
);

  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = $clog2(TAG_DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TAG_DEPTH);
  localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
  localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);
  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

  // command path state
  state_t              state_q, state_d;
  logic                winner_q, winner_d;
  logic                we_q, we_d;
  logic                app_en_q, app_en_d;
  logic [2:0]          app_cmd_q, app_cmd_d;
  logic [ADDR_W-1:0]   app_addr_q, app_addr_d;
  logic                app_wdf_wren_q, app_wdf_wren_d;
  logic                app_wdf_end_q, app_wdf_end_d;
  logic [DATA_W-1:0]   app_wdf_data_q, app_wdf_data_d;
  logic                p0_ack_q, p0_ack_d;
  logic                p1_ack_q, p1_ack_d;

  // tag FIFO and read return state
  logic                tag_mem_q [TAG_DEPTH];
  logic                tag_mem_d [TAG_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    tag_cnt_q, tag_cnt_d;
  logic                p0_rvalid_q, p0_rvalid_d;
  logic                p1_rvalid_q, p1_rvalid_d;
  logic [DATA_W-1:0]   p0_rdata_q, p0_rdata_d;
  logic [DATA_W-1:0]   p1_rdata_q, p1_rdata_d;
  logic                orphan_q, orphan_d;

  // combinational helpers
  logic full_s;
  logic elig0_s;
  logic elig1_s;
  logic grant_s;
  logic accept_s;
  logic push_s;
  logic pop_s;
  logic head_s;

`ifdef DDR2_ARB_ROUND_ROBIN_EN
  logic last_grant_q, last_grant_d;

  // Remember which port was granted most recently; updated at each accept.
  always_comb begin
    if (accept_s) begin
      last_grant_d = winner_q;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // Last-grant register; resets to port 1 so port 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  // Eligibility: reads need room in the tag FIFO (pre-pop count), writes never wait.
  always_comb begin
    full_s  = (tag_cnt_q == FULL_CNT);
    elig0_s = p0_req & (p0_we | ~full_s);
    elig1_s = p1_req & (p1_we | ~full_s);
  end

  // Pick the winning port among the eligible ones.
  always_comb begin
    grant_s = 1'b0;
    if (elig0_s && elig1_s) begin
`ifdef DDR2_ARB_ROUND_ROBIN_EN
      grant_s = ~last_grant_q;
`else
      grant_s = 1'b0;
`endif
    end else if (elig1_s) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // The controller takes the command (and write data, for writes) this cycle.
  always_comb begin
    accept_s = (state_q == ST_ISSUE) && app_rdy && (!we_q || app_wdf_rdy);
  end

  // Command FSM: next state and next app_*/ack register values.
  always_comb begin
    state_d        = state_q;
    winner_d       = winner_q;
    we_d           = we_q;
    app_en_d       = app_en_q;
    app_cmd_d      = app_cmd_q;
    app_addr_d     = app_addr_q;
    app_wdf_wren_d = app_wdf_wren_q;
    app_wdf_end_d  = app_wdf_end_q;
    app_wdf_data_d = app_wdf_data_q;
    p0_ack_d       = 1'b0;
    p1_ack_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (elig0_s || elig1_s) begin
          winner_d       = grant_s;
          we_d           = grant_s ? p1_we    : p0_we;
          app_addr_d     = grant_s ? p1_addr  : p0_addr;
          app_wdf_data_d = grant_s ? p1_wdata : p0_wdata;
          app_cmd_d      = we_d ? CMD_WR : CMD_RD;
          app_en_d       = 1'b1;
          app_wdf_wren_d = we_d;
          app_wdf_end_d  = we_d;
          state_d        = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (accept_s) begin
          app_en_d       = 1'b0;
          app_wdf_wren_d = 1'b0;
          app_wdf_end_d  = 1'b0;
          app_cmd_d      = CMD_RD;
          p0_ack_d       = ~winner_q;
          p1_ack_d       = winner_q;
          state_d        = ST_ACK;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        app_en_d       = 1'b0;
        app_wdf_wren_d = 1'b0;
        app_wdf_end_d  = 1'b0;
        app_cmd_d      = CMD_RD;
        state_d        = ST_IDLE;
      end
    endcase
  end

  // Command path registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      winner_q       <= 1'b0;
      we_q           <= 1'b0;
      app_en_q       <= 1'b0;
      app_cmd_q      <= CMD_RD;
      app_addr_q     <= {ADDR_W{1'b0}};
      app_wdf_wren_q <= 1'b0;
      app_wdf_end_q  <= 1'b0;
      app_wdf_data_q <= {DATA_W{1'b0}};
      p0_ack_q       <= 1'b0;
      p1_ack_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      winner_q       <= winner_d;
      we_q           <= we_d;
      app_en_q       <= app_en_d;
      app_cmd_q      <= app_cmd_d;
      app_addr_q     <= app_addr_d;
      app_wdf_wren_q <= app_wdf_wren_d;
      app_wdf_end_q  <= app_wdf_end_d;
      app_wdf_data_q <= app_wdf_data_d;
      p0_ack_q       <= p0_ack_d;
      p1_ack_q       <= p1_ack_d;
    end
  end

  // Tag FIFO control. A read return into an empty FIFO is still matched when
  // the read is being pushed in the same cycle; the pushed ID is the head.
  always_comb begin
    push_s = accept_s & ~we_q;
    pop_s  = app_rd_data_valid & ((tag_cnt_q != ZERO_CNT) | push_s);
    if (tag_cnt_q == ZERO_CNT) begin
      head_s = winner_q;
    end else begin
      head_s = tag_mem_q[rd_ptr_q];
    end
  end

  // Tag FIFO next state: storage, wrapping pointers and occupancy count.
  always_comb begin
    tag_mem_d = tag_mem_q;
    if (push_s) begin
      tag_mem_d[wr_ptr_q] = winner_q;
      wr_ptr_d            = wr_ptr_q + ONE_PTR;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + ONE_PTR;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   tag_cnt_d = tag_cnt_q + ONE_CNT;
      2'b01:   tag_cnt_d = tag_cnt_q - ONE_CNT;
      default: tag_cnt_d = tag_cnt_q;
    endcase
  end

  // Read return steering and the sticky orphan flag.
  always_comb begin
    p0_rvalid_d = pop_s & ~head_s;
    p1_rvalid_d = pop_s &  head_s;
    if (p0_rvalid_d) begin
      p0_rdata_d = app_rd_data;
    end else begin
      p0_rdata_d = p0_rdata_q;
    end
    if (p1_rvalid_d) begin
      p1_rdata_d = app_rd_data;
    end else begin
      p1_rdata_d = p1_rdata_q;
    end
    orphan_d = orphan_q | (app_rd_data_valid & ~pop_s);
  end

  // Tag FIFO and read return registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_mem_q   <= '{default: 1'b0};
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      tag_cnt_q   <= ZERO_CNT;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p0_rdata_q  <= {DATA_W{1'b0}};
      p1_rdata_q  <= {DATA_W{1'b0}};
      orphan_q    <= 1'b0;
    end else begin
      tag_mem_q   <= tag_mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      tag_cnt_q   <= tag_cnt_d;
      p0_rvalid_q <= p0_rvalid_d;
      p1_rvalid_q <= p1_rvalid_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
      orphan_q    <= orphan_d;
    end
  end

  assign p0_ack        = p0_ack_q;
  assign p1_ack        = p1_ack_q;
  assign p0_rvalid     = p0_rvalid_q;
  assign p1_rvalid     = p1_rvalid_q;
  assign p0_rdata      = p0_rdata_q;
  assign p1_rdata      = p1_rdata_q;
  assign app_en        = app_en_q;
  assign app_cmd       = app_cmd_q;
  assign app_addr      = app_addr_q;
  assign app_wdf_wren  = app_wdf_wren_q;
  assign app_wdf_end   = app_wdf_end_q;
  assign app_wdf_data  = app_wdf_data_q;
  assign rd_orphan_err = orphan_q;

endmodule

// File: tb/tb_ddr2_port_arbiter.sv
// Testbench for ddr2_port_arbiter: directed scenarios plus randomized traffic.
// A monitor process keeps a reference model (expected acks, queue of
// outstanding read owners, expected read returns) and compares every cycle.

module tb_ddr2_port_arbiter;

  localparam int ADDR_W    = 27;
  localparam int DATA_W    = 128;
  localparam int TAG_DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              p0_req, p0_we, p1_req, p1_we;
  logic [ADDR_W-1:0] p0_addr, p1_addr;
  logic [DATA_W-1:0] p0_wdata, p1_wdata;
  logic              p0_ack, p1_ack, p0_rvalid, p1_rvalid;
  logic [DATA_W-1:0] p0_rdata, p1_rdata;
  logic              app_rdy, app_wdf_rdy, app_rd_data_valid;
  logic [DATA_W-1:0] app_rd_data;
  logic              app_en, app_wdf_wren, app_wdf_end, rd_orphan_err;
  logic [2:0]        app_cmd;
  logic [ADDR_W-1:0] app_addr;
  logic [DATA_W-1:0] app_wdf_data;

  ddr2_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_DEPTH(TAG_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_rvalid(p0_rvalid),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_rvalid(p1_rvalid),
    .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
    .app_rd_data_valid(app_rd_data_valid), .app_en(app_en), .app_cmd(app_cmd),
    .app_addr(app_addr), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_data(app_wdf_data), .rd_orphan_err(rd_orphan_err)
  );

  initial forever #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  bit                tags[$];
  int                grant_log[$];
  logic              exp_ack[2];
  logic              exp_rv[2];
  logic [DATA_W-1:0] exp_rdata[2];
  logic              exp_orphan;
  int                en_block;
  bit                hold_valid;
  logic [2:0]        hold_cmd;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_data;
  bit                rand_on;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkn(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkd(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Issue one request on a port and wait (bounded) for its ack.
  task automatic do_req(input bit port, input bit we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] data, input int budget);
    bit got;
    got = 1'b0;
    if (port) begin
      p1_we = we; p1_addr = addr; p1_wdata = data; p1_req = 1'b1;
    end else begin
      p0_we = we; p0_addr = addr; p0_wdata = data; p0_req = 1'b1;
    end
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if ((port ? p1_ack : p0_ack) === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk1("ack_wait", got, 1'b1);
    step();
    if (port) p1_req = 1'b0;
    else p0_req = 1'b0;
  endtask

  // Return read data until the model holds no outstanding reads.
  task automatic drain();
    for (int c = 0; c < 200; c++) begin
      step();
      if (tags.size() > 0) begin
        app_rd_data_valid = 1'b1;
        app_rd_data = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        app_rd_data_valid = 1'b0;
        break;
      end
    end
    app_rd_data_valid = 1'b0;
    chkn("drain_empty", tags.size(), 0);
  endtask

  task automatic port_traffic(input bit port, input int n);
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < n; i++) begin
      a = ADDR_W'($urandom);
      a[0] = port;
      do_req(port, 1'($urandom_range(0, 1)), a,
             {$urandom, $urandom, $urandom, $urandom}, 400);
      repeat ($urandom_range(1, 3)) step();
    end
  endtask

  initial begin
    reset = 1'b1;
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
    app_rdy = 1'b0; app_wdf_rdy = 1'b0; app_rd_data_valid = 1'b0; app_rd_data = '0;
    exp_ack[0] = 1'b0; exp_ack[1] = 1'b0; exp_rv[0] = 1'b0; exp_rv[1] = 1'b0;
    exp_rdata[0] = '0; exp_rdata[1] = '0; exp_orphan = 1'b0;
    en_block = 1; hold_valid = 1'b0; rand_on = 1'b0;
    hold_cmd = 3'b001; hold_addr = '0; hold_data = '0;
    fork
      // ---------------- monitor / scoreboard ----------------
      forever begin
        bit   found, p, rd, acc;
        @(negedge clk);
        chk1("p0_ack", p0_ack, exp_ack[0]);
        chk1("p1_ack", p1_ack, exp_ack[1]);
        chk1("p0_rvalid", p0_rvalid, exp_rv[0]);
        chk1("p1_rvalid", p1_rvalid, exp_rv[1]);
        chkd("p0_rdata", p0_rdata, exp_rdata[0]);
        chkd("p1_rdata", p1_rdata, exp_rdata[1]);
        chk1("orphan_err", rd_orphan_err, exp_orphan);
        if (en_block > 0) begin
          chkn("idle_strobes", int'({app_en, app_wdf_wren, app_wdf_end}), 0);
          chkn("idle_cmd", int'(app_cmd), 1);
          en_block--;
        end
        if (hold_valid) begin
          chk1("hold_en", app_en, 1'b1);
          chkn("hold_cmd", int'(app_cmd), int'(hold_cmd));
          chkn("hold_addr", int'(app_addr), int'(hold_addr));
          chkd("hold_data", app_wdf_data, hold_data);
          hold_valid = 1'b0;
        end
        exp_ack[0] = 1'b0; exp_ack[1] = 1'b0; exp_rv[0] = 1'b0; exp_rv[1] = 1'b0;
        if (reset) begin
          tags.delete();
          exp_orphan = 1'b0;
          exp_rdata[0] = '0; exp_rdata[1] = '0;
          en_block = 1;
        end else begin
          found = 1'b0; p = 1'b0; acc = 1'b0;
          if (app_en) begin
            if (p0_req && p0_addr == app_addr) begin found = 1'b1; p = 1'b0; end
            else if (p1_req && p1_addr == app_addr) begin found = 1'b1; p = 1'b1; end
            rd  = found ? !(p ? p1_we : p0_we) : (app_cmd == 3'b001);
            acc = app_rdy && (rd || app_wdf_rdy);
          end
          if (acc) begin
            chk1("cmd_src", found, 1'b1);
            if (found) begin
              chkn("cmd_op", int'(app_cmd), rd ? 1 : 0);
              chkn("wdf_strobe", int'({app_wdf_wren, app_wdf_end}), rd ? 0 : 3);
              if (!rd) chkd("wdf_data", app_wdf_data, p ? p1_wdata : p0_wdata);
              exp_ack[p] = 1'b1;
              grant_log.push_back(int'(p));
              if (rd) begin
                chk1("tag_room", tags.size() < TAG_DEPTH, 1'b1);
                tags.push_back(p);
              end
            end
            en_block = 2;
          end else if (app_en) begin
            hold_valid = 1'b1;
            hold_cmd = app_cmd; hold_addr = app_addr; hold_data = app_wdf_data;
          end
          if (app_rd_data_valid) begin
            if (tags.size() > 0) begin
              p = tags.pop_front();
              exp_rv[p] = 1'b1;
              exp_rdata[p] = app_rd_data;
            end else begin
              exp_orphan = 1'b1;
            end
          end
        end
      end
      // ---------------- stimulus ----------------
      begin
        int g0;
        int cnt;
        bit a0, a1;
        // reset state
        do_reset();
        @(negedge clk);
        chk1("rst_app_en", app_en, 1'b0);
        chkn("rst_app_cmd", int'(app_cmd), 1);
        chkn("rst_app_addr", int'(app_addr), 0);
        chkd("rst_wdf_data", app_wdf_data, '0);
        chk1("rst_orphan", rd_orphan_err, 1'b0);

        // single write with controller ready: app_en at T+1, ack at T+2
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        step();
        p0_we = 1'b1; p0_addr = 27'h10; p0_wdata = {16{8'hA5}}; p0_req = 1'b1;
        @(negedge clk);
        chk1("wr_en_T", app_en, 1'b0);
        @(negedge clk);
        chkn("wr_strobes_T1", int'({app_en, app_wdf_wren, app_wdf_end}), 7);
        chkn("wr_cmd_T1", int'(app_cmd), 0);
        chkn("wr_addr_T1", int'(app_addr), 'h10);
        chkd("wr_data_T1", app_wdf_data, {16{8'hA5}});
        @(negedge clk);
        chk1("wr_ack_T2", p0_ack, 1'b1);
        chk1("wr_en_T2", app_en, 1'b0);
        step();
        p0_req = 1'b0;
        @(negedge clk);
        chk1("wr_ack_T3", p0_ack, 1'b0);

        // read held off by app_rdy for 5 cycles, then data returned
        app_rdy = 1'b0;
        step();
        p1_we = 1'b0; p1_addr = 27'h20; p1_req = 1'b1;
        for (int i = 1; i <= 6; i++) begin
          step();
          if (i == 6) app_rdy = 1'b1;
          @(negedge clk);
          chk1("rd_hold_en", app_en, 1'b1);
          chkn("rd_hold_addr", int'(app_addr), 'h20);
          chk1("rd_no_ack", p1_ack, 1'b0);
        end
        @(negedge clk);
        chk1("rd_ack", p1_ack, 1'b1);
        step();
        p1_req = 1'b0;
        app_rd_data_valid = 1'b1; app_rd_data = {16{8'h55}};
        step();
        app_rd_data_valid = 1'b0;
        @(negedge clk);
        chk1("rd_ret_p1_rvalid", p1_rvalid, 1'b1);
        chkd("rd_ret_p1_rdata", p1_rdata, {16{8'h55}});
        chk1("rd_ret_p0_rvalid", p0_rvalid, 1'b0);

        // FIFO full: fifth read waits, other port's write proceeds
        for (int i = 0; i < 4; i++) do_req(1'b0, 1'b0, ADDR_W'(32'h100 + 2 * i), '0, 50);
        g0 = grant_log.size();
        fork
          do_req(1'b0, 1'b0, 27'h108, '0, 300);
          begin
            repeat (10) step();
            chkn("full_withheld", grant_log.size(), g0);
            do_req(1'b1, 1'b1, 27'h31, {4{32'hC0FFEE01}}, 50);
            chkn("full_wr_pass", grant_log.size(), g0 + 1);
            chkn("full_wr_port", grant_log[grant_log.size() - 1], 1);
            app_rd_data_valid = 1'b1; app_rd_data = {4{32'h12345678}};
            step();
            app_rd_data_valid = 1'b0;
          end
        join
        chkn("full_fifth_issued", grant_log.size(), g0 + 2);
        chkn("full_fifth_port", grant_log[grant_log.size() - 1], 0);
        drain();

        // tie between both ports with continuous requests
        do_reset();
        g0 = grant_log.size();
        p0_we = 1'b1; p0_addr = 27'h40; p0_wdata = {4{32'hAAAA0000}}; p0_req = 1'b1;
        p1_we = 1'b1; p1_addr = 27'h41; p1_wdata = {4{32'hBBBB1111}}; p1_req = 1'b1;
        cnt = 0;
        for (int c = 0; c < 60; c++) begin
          @(negedge clk);
          a0 = p0_ack; a1 = p1_ack;
          step();
          if (a0) p0_addr = p0_addr + 27'd2;
          if (a1) p1_addr = p1_addr + 27'd2;
          cnt = grant_log.size() - g0;
          if (cnt >= 6) break;
        end
        p0_req = 1'b0; p1_req = 1'b0;
        chkn("tie_count", cnt, 6);
        for (int i = 0; i < 6 && g0 + i < grant_log.size(); i++) begin
`ifdef DDR2_ARB_ROUND_ROBIN_EN
          chkn("tie_order", grant_log[g0 + i], i % 2);
`else
          chkn("tie_order", grant_log[g0 + i], 0);
`endif
        end
        repeat (3) step();

        // orphaned read data after reset
        do_reset();
        app_rd_data_valid = 1'b1; app_rd_data = {4{32'hDEADBEEF}};
        step();
        app_rd_data_valid = 1'b0;
        @(negedge clk);
        chk1("orph_p0_rvalid", p0_rvalid, 1'b0);
        chk1("orph_p1_rvalid", p1_rvalid, 1'b0);
        chk1("orph_err_set", rd_orphan_err, 1'b1);
        repeat (3) step();
        @(negedge clk);
        chk1("orph_err_sticky", rd_orphan_err, 1'b1);
        do_reset();
        @(negedge clk);
        chk1("orph_err_cleared", rd_orphan_err, 1'b0);

        // reset in the middle of ISSUE abandons the command
        app_rdy = 1'b0;
        step();
        p0_we = 1'b1; p0_addr = 27'h50; p0_wdata = {4{32'h0BADF00D}}; p0_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk1("mid_en_before", app_en, 1'b1);
        step();
        reset = 1'b1; p0_req = 1'b0;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk1("mid_en_after", app_en, 1'b0);
        chk1("mid_no_ack", p0_ack, 1'b0);
        repeat (3) begin
          @(negedge clk);
          chk1("mid_no_ack_later", p0_ack, 1'b0);
        end

        // randomized traffic from both ports against a random controller
        do_reset();
        rand_on = 1'b1;
        fork
          begin
            fork
              port_traffic(1'b0, 30);
              port_traffic(1'b1, 30);
            join
            rand_on = 1'b0;
          end
          while (rand_on) begin
            step();
            app_rdy = ($urandom_range(0, 3) != 0);
            app_wdf_rdy = ($urandom_range(0, 3) != 0);
            if (tags.size() > 0 && $urandom_range(0, 2) == 0) begin
              app_rd_data_valid = 1'b1;
              app_rd_data = {$urandom, $urandom, $urandom, $urandom};
            end else begin
              app_rd_data_valid = 1'b0;
            end
          end
        join
        app_rd_data_valid = 1'b0;
        drain();
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
      end
      // ---------------- watchdog ----------------
      begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog expired");
      end
    join
  end

endmodule
